aether_pifo: RTL and testbench
==============================

// Module: aether_pifo
//
// PURPOSE
//   Push-In First-Out (PIFO) priority queue for packet scheduling.
//   Entries carry a priority (low PTW bits) and metadata (upper MTW bits).
//   Pop always returns the smallest-priority entry present; equal priorities leave in arrival order.
//   Top-level scheduler queue; one push and/or one pop per cycle.
//
// PARAMETERS
//   PTW    16  priority width in bits; unsigned; smaller value = served first
//   MTW    32  metadata width in bits; opaque, carried unchanged
//   LEVEL  3   depth control; capacity N = 2**LEVEL entries (LEVEL=3 -> 8)
//
// PORTS
//   i_clk   in   1        single clock; all state changes on its rising edge
//   i_rst   in   1        reset; synchronous, active-high
//   i_push  in   1        push request, sampled on rising edge
//   i_pop   in   1        pop request, sampled on rising edge
//   i_data  in   MTW+PTW  entry to push: [MTW+PTW-1:PTW]=meta, [PTW-1:0]=priority
//   o_data  out  MTW+PTW  registered; last popped entry, same packing as i_data
//   o_ready out  1        1 = queue can accept a push (not full, not in reset)
//
// BEHAVIOUR
//   - Storage: N slots kept sorted ascending by priority (slot 0 = head), plus a count 0..N.
//     Any structure (shift-register sorted array or tree) is acceptable if results match this model.
//   - Reset (i_rst=1 at an edge): count=0, o_data=0, all slots cleared.
//     o_ready=0 while i_rst is asserted; 1 on the first cycle after release.
//     Reset mid-operation discards all contents.
//   - Push only (count<N): insert after the last slot whose priority <= new priority (FIFO on ties).
//     Shift later slots down one; count+1.
//   - Push when count==N (without pop): entry dropped silently; state unchanged.
//     o_ready = !i_rst && (count < N), combinational from registered count.
//   - Pop only (count>0): o_data <= slot 0 at that edge; remaining slots shift up; count-1.
//   - Pop when count==0: ignored; o_data holds its previous value; count stays 0.
//   - Push+pop same edge, count>0: o_data <= current head (pre-push contents, even if the new
//     priority is smaller). Head is removed, new entry inserted into the rest; count unchanged.
//     Allowed when full.
//   - Push+pop same edge, count==0: the pop is ignored and the push proceeds normally.
//   - Latency: a pushed entry is eligible for a pop sampled on the very next edge.
//     o_data is valid the cycle after the pop edge and holds until the next successful pop.
//   - Comparisons unsigned on PTW bits only; metadata never affects ordering.
//
// TESTING
//   1 Reset: assert i_rst 3 cycles -> o_data==0, o_ready==0. Release -> o_ready==1, pop -> o_data stays 0.
//   2 Ordering: push (pri,meta) (100,A1),(50,B2),(150,C3),(10,D4); pop x4.
//     -> priorities 10,50,100,150 with metas D4,B2,A1,C3.
//   3 Tie FIFO: push (7,01),(7,02),(7,03); pop x3 -> metas 01,02,03.
//   4 Full: LEVEL=3, push 9 entries pri 9..1 -> o_ready==0 after 8th; 9th (pri 1) dropped.
//     First pop returns pri 2.
//   5 Simultaneous: queue {20,30}; push 5 + pop same edge -> o_data pri 20. Next pops: 5, then 30.
//   6 Empty pop / mid-reset: pop on empty -> o_data unchanged. Push 3 entries, pulse i_rst 1 cycle -> pop ignored.

Source files
------------

// File: rtl/aether_pifo.sv
// aether_pifo: push-in first-out priority queue built as a sorted shift array.
// Slot 0 always holds the smallest priority; equal priorities keep arrival order.
// One push and/or one pop is handled on every rising clock edge.
module aether_pifo #(
  parameter int PTW   = 16,
  parameter int MTW   = 32,
  parameter int LEVEL = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [MTW+PTW-1:0] i_data,
  output logic [MTW+PTW-1:0] o_data,
  output logic               o_ready
);

  localparam int N  = 2 ** LEVEL;
  localparam int DW = MTW + PTW;
  localparam int CW = LEVEL + 1;

  logic [DW-1:0] slot_q [N];
  logic [DW-1:0] slot_d [N];
  logic [DW-1:0] base_s [N];
  logic [CW-1:0] count_q, count_d, base_cnt_s;
  logic [DW-1:0] data_q, data_d;
  logic [N-1:0]  le_s;
  logic          do_pop_s, do_push_s;

  // Next-state: remove the head on a pop, then insert the new entry after the last slot with priority <= its own.
  always_comb begin
    do_pop_s  = i_pop && (count_q != CW'(0));
    do_push_s = i_push && ((count_q < CW'(N)) || do_pop_s);

    for (int k = 0; k < N - 1; k++) begin
      base_s[k] = do_pop_s ? slot_q[k+1] : slot_q[k];
    end
    base_s[N-1] = do_pop_s ? {DW{1'b0}} : slot_q[N-1];
    base_cnt_s  = do_pop_s ? (count_q - CW'(1)) : count_q;

    // Because the array is sorted, le_s is a prefix mask of slots staying ahead of the new entry.
    for (int k = 0; k < N; k++) begin
      le_s[k] = (CW'(k) < base_cnt_s) && (base_s[k][PTW-1:0] <= i_data[PTW-1:0]);
    end

    if (do_push_s) begin
      slot_d[0] = le_s[0] ? base_s[0] : i_data;
      for (int k = 1; k < N; k++) begin
        if (le_s[k]) begin
          slot_d[k] = base_s[k];
        end else if (le_s[k-1]) begin
          slot_d[k] = i_data;
        end else begin
          slot_d[k] = base_s[k-1];
        end
      end
      count_d = base_cnt_s + CW'(1);
    end else begin
      for (int k = 0; k < N; k++) begin
        slot_d[k] = base_s[k];
      end
      count_d = base_cnt_s;
    end

    data_d = do_pop_s ? slot_q[0] : data_q;
  end

  // State registers with synchronous reset that discards every entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < N; k++) begin
        slot_q[k] <= {DW{1'b0}};
      end
      count_q <= {CW{1'b0}};
      data_q  <= {DW{1'b0}};
    end else begin
      for (int k = 0; k < N; k++) begin
        slot_q[k] <= slot_d[k];
      end
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  assign o_data  = data_q;
  assign o_ready = !i_rst && (count_q < CW'(N));

endmodule

// File: tb/tb_aether_pifo.sv
// Self-checking bench for aether_pifo: a queue-based reference model predicts
// each pop result into a scoreboard that is compared after the clock edge.
module tb_aether_pifo;

  localparam int PTW = 16;
  localparam int MTW = 32;
  localparam int DW  = PTW + MTW;
  localparam int N   = 8;

  logic          i_clk;
  logic          i_rst;
  logic          i_push;
  logic          i_pop;
  logic [DW-1:0] i_data;
  logic [DW-1:0] o_data;
  logic          o_ready;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] m_last;

  aether_pifo #(.PTW(PTW), .MTW(MTW), .LEVEL(3)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (i_push),
    .i_pop  (i_pop),
    .i_data (i_data),
    .o_data (o_data),
    .o_ready(o_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ent(input logic [15:0] pri, input logic [31:0] meta);
    return {meta, pri};
  endfunction

  // One clock of stimulus; the model predicts the pop result and o_ready.
  task automatic step(input logic push, input logic pop, input logic [DW-1:0] d, input string tag);
    bit full;
    bit popped;
    int idx;
    @(negedge i_clk);
    i_push = push;
    i_pop  = pop;
    i_data = d;
    full   = (mq.size() == N);
    popped = 1'b0;
    if (pop) begin
      if (mq.size() > 0) begin
        m_last = mq.pop_front();
        popped = 1'b1;
      end
      sb.push_back(m_last);
    end
    if (push && (!full || popped)) begin
      idx = 0;
      while (idx < mq.size() && mq[idx][PTW-1:0] <= d[PTW-1:0]) idx++;
      mq.insert(idx, d);
    end
    @(posedge i_clk);
    #1;
    if (sb.size() > 0) check_val({tag, ".data"}, o_data, sb.pop_front());
    check_val({tag, ".ready"}, {{(DW-1){1'b0}}, o_ready}, {{(DW-1){1'b0}}, mq.size() < N});
    i_push = 1'b0;
    i_pop  = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge i_clk);
    i_rst  = 1'b1;
    i_push = 1'b0;
    i_pop  = 1'b0;
    repeat (cycles) @(posedge i_clk);
    #1;
    check_val("rst.data", o_data, {DW{1'b0}});
    check_val("rst.ready", {{(DW-1){1'b0}}, o_ready}, {DW{1'b0}});
    mq.delete();
    sb.delete();
    m_last = {DW{1'b0}};
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check_val("rel.ready", {{(DW-1){1'b0}}, o_ready}, {{(DW-1){1'b0}}, 1'b1});
  endtask

  initial begin
    i_rst  = 1'b1;
    i_push = 1'b0;
    i_pop  = 1'b0;
    i_data = {DW{1'b0}};
    m_last = {DW{1'b0}};

    // 1: reset, then pop on empty keeps o_data at zero
    do_reset(3);
    step(1'b0, 1'b1, {DW{1'b0}}, "t1.pop");

    // 2: ordering
    step(1'b1, 1'b0, ent(16'd100, 32'hA1), "t2.push");
    step(1'b1, 1'b0, ent(16'd50,  32'hB2), "t2.push");
    step(1'b1, 1'b0, ent(16'd150, 32'hC3), "t2.push");
    step(1'b1, 1'b0, ent(16'd10,  32'hD4), "t2.push");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, {DW{1'b0}}, "t2.pop");

    // 3: ties leave in arrival order
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, ent(16'd7, 32'(i)), "t3.push");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, {DW{1'b0}}, "t3.pop");

    // 4: fill with pri 9..1, ninth dropped, then push+pop while full, then drain
    for (int p = 9; p >= 1; p--) step(1'b1, 1'b0, ent(16'(p), 32'(100 + p)), "t4.push");
    step(1'b0, 1'b1, {DW{1'b0}}, "t4.pop");
    step(1'b1, 1'b0, ent(16'd4, 32'hF0), "t4.refill");
    step(1'b1, 1'b1, ent(16'd0, 32'hF1), "t4.pushpop");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, {DW{1'b0}}, "t4.drain");

    // 5: simultaneous push+pop returns the old head
    step(1'b1, 1'b0, ent(16'd20, 32'h20), "t5.push");
    step(1'b1, 1'b0, ent(16'd30, 32'h30), "t5.push");
    step(1'b1, 1'b1, ent(16'd5,  32'h05), "t5.pushpop");
    step(1'b0, 1'b1, {DW{1'b0}}, "t5.pop");
    step(1'b0, 1'b1, {DW{1'b0}}, "t5.pop");

    // 6: empty pop, push+pop on empty, mid-operation reset
    step(1'b0, 1'b1, {DW{1'b0}}, "t6.emptypop");
    step(1'b1, 1'b1, ent(16'd9, 32'h99), "t6.pushpop_empty");
    step(1'b0, 1'b1, {DW{1'b0}}, "t6.pop");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, ent(16'(40 + i), 32'(i)), "t6.push");
    do_reset(1);
    step(1'b0, 1'b1, {DW{1'b0}}, "t6.pop_after_rst");

    // Random mix with a narrow priority range to exercise ties and fullness
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
           ent(16'($urandom_range(0, 15)), $urandom), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
